// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - SPI command decoder sharing one RAM port with a host requester
// Optional feature: define ADDR_AUTO_INC_EN to post-increment wr_addr/rd_addr on SPI opcodes 01/11.
module spi_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              spi_ovf
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SPI_ACC  = 2'd1,
    S_HOST_ACC = 2'd2,
    S_RD_WAIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              spi_pend_q, spi_pend_d;
  logic [ADDR_W+1:0] spi_word_q, spi_word_d;
  logic              spi_ovf_q, spi_ovf_d;
  logic              rd_spi_q, rd_spi_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              host_gnt_q, host_gnt_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  // A buffered word takes precedence over the live strobe so commands stay in order
  logic              spi_work;
  logic [ADDR_W+1:0] cmd_word;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_payload;

  assign spi_work    = rx_valid || spi_pend_q;
  assign cmd_word    = spi_pend_q ? spi_word_q : rx_data;
  assign cmd_op      = cmd_word[ADDR_W+1:ADDR_W];
  assign cmd_payload = cmd_word[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: SPI opcodes 01/11 and any granted host request claim the RAM port
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (spi_work) begin
          if (cmd_op[0]) state_d = S_SPI_ACC;
        end else if (host_req) begin
          state_d = S_HOST_ACC;
        end
      end
      S_SPI_ACC, S_HOST_ACC: state_d = ram_we_q ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: compute next values of all registered outputs and buffers
  always_comb begin
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    spi_pend_d    = spi_pend_q;
    spi_word_d    = spi_word_q;
    spi_ovf_d     = spi_ovf_q;
    rd_spi_d      = rd_spi_q;
    ram_en_d      = 1'b0;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    host_gnt_d    = 1'b0;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;

    // The one-entry buffer drains in IDLE; a strobe arriving while it is full is lost
    if (state_q == S_IDLE && spi_pend_q) spi_pend_d = 1'b0;
    if (rx_valid) begin
      if (spi_pend_q) begin
        spi_ovf_d = 1'b1;
      end else if (state_q != S_IDLE) begin
        spi_word_d = rx_data;
        spi_pend_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (spi_work) begin
          case (cmd_op)
            2'b00: wr_addr_d = cmd_payload;
            2'b10: rd_addr_d = cmd_payload;
            2'b01: begin
              ram_en_d    = 1'b1;
              ram_we_d    = 1'b1;
              ram_addr_d  = wr_addr_q;
              ram_wdata_d = DATA_W'(cmd_payload);
`ifdef ADDR_AUTO_INC_EN
              wr_addr_d   = wr_addr_q + ADDR_W'(1);
`else
              wr_addr_d   = wr_addr_q;
`endif
            end
            default: begin
              ram_en_d   = 1'b1;
              ram_we_d   = 1'b0;
              ram_addr_d = rd_addr_q;
              rd_spi_d   = 1'b1;
`ifdef ADDR_AUTO_INC_EN
              rd_addr_d  = rd_addr_q + ADDR_W'(1);
`else
              rd_addr_d  = rd_addr_q;
`endif
            end
          endcase
        end else if (host_req) begin
          host_gnt_d  = 1'b1;
          ram_en_d    = 1'b1;
          ram_we_d    = host_we;
          ram_addr_d  = host_addr;
          ram_wdata_d = host_wdata;
          rd_spi_d    = 1'b0;
        end
      end
      S_RD_WAIT: begin
        if (rd_spi_q) begin
          tx_data_d  = ram_rdata;
          tx_valid_d = 1'b1;
        end else begin
          host_rdata_d  = ram_rdata;
          host_rvalid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      spi_pend_q    <= 1'b0;
      spi_word_q    <= '0;
      spi_ovf_q     <= 1'b0;
      rd_spi_q      <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      spi_pend_q    <= spi_pend_d;
      spi_word_q    <= spi_word_d;
      spi_ovf_q     <= spi_ovf_d;
      rd_spi_q      <= rd_spi_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      host_gnt_q    <= host_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign host_gnt    = host_gnt_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign spi_ovf     = spi_ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - directed self-checking bench for spi_ram_arbiter
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       spi_ovf;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
  );

  // Single-port RAM model: synchronous write, read data one cycle after enable
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one SPI word for one cycle; returns in cycle T+1
  task automatic spi(input logic [1:0] op, input logic [7:0] pl);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_req = 1'b0;
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    idle(3);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_spi_ovf", spi_ovf, 0);
    #2 rst_n = 1'b1;
    idle(2);

    // Write then read through SPI
    spi(2'b00, 8'h3C);
    check("wa_no_ram", ram_en, 0);
    idle(2);
    spi(2'b01, 8'hA5);
    check("wr_en", ram_en, 1);
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_addr, 8'h3C);
    check("wr_data", ram_wdata, 8'hA5);
    tick();
    check("wr_en_drop", ram_en, 0);
    idle(2);
    check("mem_3c", mem[8'h3C], 8'hA5);
    spi(2'b10, 8'h3C);
    idle(2);
    spi(2'b11, 8'h00);
    check("rd_en", ram_en, 1);
    check("rd_we", ram_we, 0);
    check("rd_addr", ram_addr, 8'h3C);
    tick();
    check("rd_t2_txv", tx_valid, 0);
    check("rd_t2_en", ram_en, 0);
    tick();
    check("rd_t3_txv", tx_valid, 1);
    check("rd_t3_txd", tx_data, 8'hA5);
    tick();
    check("rd_t4_txv", tx_valid, 0);
    check("rd_hold_txd", tx_data, 8'hA5);
    idle(2);

    // Host read of a location preloaded through a host write
    host_wr(8'h10, 8'h5A);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    tick();
    check("hr_gnt", host_gnt, 1);
    check("hr_en", ram_en, 1);
    check("hr_addr", ram_addr, 8'h10);
    host_req = 1'b0;
    tick();
    check("hr_h2_gnt", host_gnt, 0);
    check("hr_h2_rv", host_rvalid, 0);
    tick();
    check("hr_h3_rv", host_rvalid, 1);
    check("hr_h3_rd", host_rdata, 8'h5A);
    tick();
    check("hr_h4_rv", host_rvalid, 0);
    idle(2);

    // Collision: SPI write and host write in the same cycle
    spi(2'b00, 8'h40);
    idle(2);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h50; host_wdata = 8'h99;
    spi(2'b01, 8'h77);
    check("col_spi_addr", ram_addr, 8'h40);
    check("col_spi_data", ram_wdata, 8'h77);
    check("col_t1_gnt", host_gnt, 0);
    tick();
    check("col_t2_gnt", host_gnt, 0);
    tick();
    check("col_t3_gnt", host_gnt, 1);
    check("col_host_addr", ram_addr, 8'h50);
    check("col_host_we", ram_we, 1);
    host_req = 1'b0;
    idle(2);
    check("col_mem_40", mem[8'h40], 8'h77);
    check("col_mem_50", mem[8'h50], 8'h99);

    // Buffering and overflow around a host read
    spi(2'b00, 8'h80);
    idle(2);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    tick();
    check("buf_gnt", host_gnt, 1);
    host_req = 1'b0;
    rx_data = {2'b01, 8'hC3}; rx_valid = 1'b1;
    tick();
    rx_data = {2'b01, 8'hEE}; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("buf_ovf", spi_ovf, 1);
    check("buf_host_rv", host_rvalid, 1);
    check("buf_en_h3", ram_en, 0);
    tick();
    check("buf_en", ram_en, 1);
    check("buf_we", ram_we, 1);
    check("buf_addr", ram_addr, 8'h80);
    check("buf_data", ram_wdata, 8'hC3);
    tick();
    check("buf_no2nd_a", ram_en, 0);
    tick();
    check("buf_no2nd_b", ram_en, 0);
    check("buf_mem_80", mem[8'h80], 8'hC3);
    check("buf_ovf_sticky", spi_ovf, 1);

    // Address wrap / auto-increment
    host_wr(8'h00, 8'h00);
    spi(2'b00, 8'hFF);
    idle(2);
    spi(2'b01, 8'h11);
    idle(2);
    spi(2'b01, 8'h22);
    idle(2);
`ifdef ADDR_AUTO_INC_EN
    check("inc_mem_ff", mem[8'hFF], 8'h11);
    check("inc_mem_00", mem[8'h00], 8'h22);
`else
    check("inc_mem_ff", mem[8'hFF], 8'h22);
    check("inc_mem_00", mem[8'h00], 8'h00);
`endif

    // Reset during RD_WAIT
    host_wr(8'h00, 8'h3E);
    spi(2'b10, 8'h80);
    idle(2);
    spi(2'b11, 8'h00);
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_tx_valid", tx_valid, 0);
    check("mr_tx_data", tx_data, 0);
    check("mr_ram_en", ram_en, 0);
    check("mr_ram_addr", ram_addr, 0);
    check("mr_spi_ovf", spi_ovf, 0);
    check("mr_host_rdata", host_rdata, 0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_txv", tx_valid, 0);
    end
    spi(2'b11, 8'h00);
    check("mr_rd_addr0", ram_addr, 8'h00);
    idle(2);
    check("mr_rd_txv", tx_valid, 1);
    check("mr_rd_txd", tx_data, 8'h3E);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
